accumulator_scheduler: RTL and testbench



---
 rtl/accumulator_scheduler.sv | 187 ++++++++++++++++++
 tb/tb_accumulator_scheduler.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : accumulator_scheduler
// Description : Round-robin time-sharing of one accumulate datapath between
//               NUM_REQ sample streams. A granted stream supplies a fixed
//               number of beats, the sum is emitted tagged with the stream
//               id, then the accumulator clears and arbitration repeats.
//               Optional idle-beat timeout: define ACC_SCHED_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module accumulator_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int ACC_WIDTH      = 40,
    parameter int LEN_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [LEN_WIDTH-1:0]          cfg_len,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          res_valid,
    input  logic                          res_ready,
    output logic [ACC_WIDTH-1:0]          res_data,
    output logic [$clog2(NUM_REQ)-1:0]    res_id,
    output logic                          res_partial,
    output logic                          busy
);

    localparam int c_ID_W = $clog2(NUM_REQ);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_EMIT  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ACC_WIDTH-1:0]  r_acc;
    logic [LEN_WIDTH-1:0]  r_count;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [c_ID_W-1:0]     r_grant;
    logic [c_ID_W-1:0]     r_last_grant;

    logic [c_ID_W:0]       w_idx;
    logic [c_ID_W-1:0]     w_pick;
    logic                  w_found;
    logic [DATA_WIDTH-1:0] w_sample;
    logic [LEN_WIDTH-1:0]  w_len_eff;
    logic                  w_beat;
    logic                  w_last_beat;
    logic                  w_handshake;
    logic                  w_timeout;

    // Round-robin search starting one past the most recently served stream
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = {1'b0, r_last_grant} + (c_ID_W+1)'(i);
            if (w_idx >= (c_ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (c_ID_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_idx[c_ID_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_idx[c_ID_W-1:0];
            end
        end
    end

    // A programmed length of zero still means one beat
    assign w_len_eff   = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
    assign w_sample    = req_data[r_grant*DATA_WIDTH +: DATA_WIDTH];
    assign w_beat      = (r_state == c_ST_ACCUM) && req_valid[r_grant];
    assign w_last_beat = w_beat && ((r_count + LEN_WIDTH'(1)) == r_len);
    assign w_handshake = (r_state == c_ST_EMIT) && res_ready;

    assign req_ready = (r_state == c_ST_ACCUM) ? (NUM_REQ'(1) << r_grant) : '0;
    assign res_valid = (r_state == c_ST_EMIT);
    assign res_data  = r_acc;
    assign res_id    = r_grant;
    assign busy      = (r_state != c_ST_IDLE);

`ifdef ACC_SCHED_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [c_TO_W-1:0] r_idle_cnt;
    logic              r_partial;

    assign w_timeout   = (r_state == c_ST_ACCUM) && !w_beat &&
                         (r_idle_cnt == c_TO_W'(TIMEOUT_CYCLES - 1));
    assign res_partial = r_partial;

    // Count consecutive beat-less ACCUM cycles; any beat restarts the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if ((r_state != c_ST_ACCUM) || w_beat) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + c_TO_W'(1);
        end
    end

    // Flag a result cut short by the idle limit until it is consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_partial <= 1'b0;
        end else if (w_timeout) begin
            r_partial <= 1'b1;
        end else if (w_handshake) begin
            r_partial <= 1'b0;
        end
    end
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign w_timeout        = 1'b0;
    assign res_partial      = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = c_ST_ACCUM;
                end
            end
            c_ST_ACCUM: begin
                if (w_last_beat || w_timeout) begin
                    w_state_nxt = c_ST_EMIT;
                end
            end
            c_ST_EMIT: begin
                if (res_ready) begin
                    w_state_nxt = c_ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Grant capture, accumulation and post-handshake clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc        <= '0;
            r_count      <= '0;
            r_len        <= LEN_WIDTH'(1);
            r_grant      <= '0;
            r_last_grant <= c_ID_W'(NUM_REQ - 1);
        end else begin
            if ((r_state == c_ST_IDLE) && w_found) begin
                r_grant <= w_pick;
                r_len   <= w_len_eff;
                r_acc   <= '0;
                r_count <= '0;
            end
            if (w_beat) begin
                r_acc   <= r_acc + ACC_WIDTH'(w_sample);
                r_count <= r_count + LEN_WIDTH'(1);
            end
            if (w_handshake) begin
                r_acc        <= '0;
                r_count      <= '0;
                r_last_grant <= r_grant;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_accumulator_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_accumulator_scheduler
// Description : Scoreboard bench for accumulator_scheduler. A 40-bit and a
//               32-bit accumulator instance share the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accumulator_scheduler;

    localparam int c_NR = 4;
    localparam int c_DW = 32;
    localparam int c_LW = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [c_LW-1:0]        cfg_len;
    logic [c_NR-1:0]        req_valid;
    logic [c_NR*c_DW-1:0]   req_data;
    logic                   res_ready;

    logic [c_NR-1:0]        req_ready;
    logic                   res_valid;
    logic [39:0]            res_data;
    logic [1:0]             res_id;
    logic                   res_partial;
    logic                   busy;

    logic [c_NR-1:0]        req_ready32;
    logic                   res_valid32;
    logic [31:0]            res_data32;
    logic [1:0]             res_id32;
    logic                   res_partial32;
    logic                   busy32;

    typedef struct {
        logic [1:0]  id;
        logic [39:0] d40;
        logic [31:0] d32;
        logic        part;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] smp [4];
    int          wcyc;

    always #5 clk = ~clk;

    accumulator_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(32), .ACC_WIDTH(40), .LEN_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready), .res_valid(res_valid),
        .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
        .res_partial(res_partial), .busy(busy)
    );

    accumulator_scheduler #(
        .NUM_REQ(4), .DATA_WIDTH(32), .ACC_WIDTH(32), .LEN_WIDTH(8), .TIMEOUT_CYCLES(16)
    ) u_dut32 (
        .clk(clk), .rst(rst), .cfg_len(cfg_len), .req_valid(req_valid),
        .req_data(req_data), .req_ready(req_ready32), .res_valid(res_valid32),
        .res_ready(res_ready), .res_data(res_data32), .res_id(res_id32),
        .res_partial(res_partial32), .busy(busy32)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input int id, input logic [63:0] sum, input logic part);
        exp_t e;
        e.id   = 2'(id);
        e.d40  = sum[39:0];
        e.d32  = sum[31:0];
        e.part = part;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // Offer n samples from smp[] on stream id; wcyc = cycles waited for first ready
    task automatic send_burst(input int id, input int n, output int wait_cyc);
        int k     = 0;
        int guard = 0;
        bit seen  = 0;
        wait_cyc = 0;
        req_data[id*c_DW +: c_DW] = smp[0];
        req_valid[id] = 1'b1;
        while (k < n && guard < 100) begin
            @(negedge clk);
            if (req_ready[id]) begin
                k++;
                seen = 1;
            end else if (!seen) begin
                wait_cyc++;
            end
            @(posedge clk);
            #1;
            if (k < n) req_data[id*c_DW +: c_DW] = smp[k];
            else       req_valid[id] = 1'b0;
            guard++;
        end
        check_eq("burst_beats", 64'(k), 64'(n));
    endtask

    task automatic wait_drain();
        int g = 0;
        while (sb.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        check_eq("drain", 64'(sb.size()), 64'd0);
    endtask

    // Scoreboard: compare every accepted result against the oldest expectation
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst) begin
            check_eq("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
            if (res_valid && res_ready) begin
                check_eq("result_expected", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check_eq("res_id",      64'(res_id),      64'(e.id));
                    check_eq("res_data",    64'(res_data),    64'(e.d40));
                    check_eq("res_partial", 64'(res_partial), 64'(e.part));
                    check_eq("res_valid32", 64'(res_valid32), 64'd1);
                    check_eq("res_data32",  64'(res_data32),  64'(e.d32));
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog got=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int n_seen;
        int guard;
        rst       = 1'b1;
        cfg_len   = '0;
        req_valid = '0;
        req_data  = '0;
        res_ready = 1'b1;
        do_reset();

        // Reset state
        @(negedge clk);
        check_eq("rst_req_ready",   64'(req_ready),   64'd0);
        check_eq("rst_res_valid",   64'(res_valid),   64'd0);
        check_eq("rst_res_data",    64'(res_data),    64'd0);
        check_eq("rst_res_id",      64'(res_id),      64'd0);
        check_eq("rst_res_partial", 64'(res_partial), 64'd0);
        check_eq("rst_busy",        64'(busy),        64'd0);
        tick();

        // Stream 2, three beats 5,7,9
        cfg_len = 8'd3;
        smp[0] = 32'd5; smp[1] = 32'd7; smp[2] = 32'd9; smp[3] = 32'd0;
        push_exp(2, 64'd21, 1'b0);
        send_burst(2, 3, wcyc);
        check_eq("first_ready_latency", 64'(wcyc), 64'd1);
        @(negedge clk);
        check_eq("ready_drop_after_last", 64'(req_ready), 64'd0);
        wait_drain();

        // All streams valid, single-beat bursts: round-robin order 0,1,2,3,0
        do_reset();
        cfg_len = 8'd1;
        for (int i = 0; i < c_NR; i++) req_data[i*c_DW +: c_DW] = 32'h100 + 32'(i);
        for (int i = 0; i < 5; i++) push_exp(i % c_NR, 64'h100 + 64'(i % c_NR), 1'b0);
        req_valid = 4'hF;
        n_seen = 0;
        guard  = 0;
        while (n_seen < 5 && guard < 100) begin
            @(negedge clk);
            if (res_valid && res_ready) n_seen++;
            if (n_seen == 5) req_valid = '0;
            guard++;
        end
        check_eq("rr_results", 64'(n_seen), 64'd5);
        wait_drain();

        // Wrap: two max samples on stream 1
        cfg_len = 8'd2;
        smp[0] = 32'hFFFF_FFFF; smp[1] = 32'hFFFF_FFFF;
        push_exp(1, 64'hFFFF_FFFF + 64'hFFFF_FFFF, 1'b0);
        send_burst(1, 2, wcyc);
        wait_drain();

        // cfg_len=0 means one beat; result held under back-pressure
        res_ready = 1'b0;
        cfg_len   = 8'd0;
        smp[0] = 32'd4;
        push_exp(0, 64'd4, 1'b0);
        send_burst(0, 1, wcyc);
        cfg_len = 8'd1;
        req_data[3*c_DW +: c_DW] = 32'h33;
        req_valid[3] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("hold_res_valid", 64'(res_valid), 64'd1);
            check_eq("hold_res_data",  64'(res_data),  64'd4);
            check_eq("hold_res_id",    64'(res_id),    64'd0);
            check_eq("hold_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        smp[0] = 32'h33;
        push_exp(3, 64'h33, 1'b0);
        send_burst(3, 1, wcyc);
        wait_drain();

        // Reset mid-burst discards partial sum; stream 0 wins afterwards
        cfg_len = 8'd4;
        smp[0] = 32'd100; smp[1] = 32'd200;
        send_burst(1, 2, wcyc);
        do_reset();
        @(negedge clk);
        check_eq("abort_busy",      64'(busy),      64'd0);
        check_eq("abort_res_valid", 64'(res_valid), 64'd0);
        check_eq("abort_res_data",  64'(res_data),  64'd0);
        tick();
        cfg_len = 8'd2;
        smp[0] = 32'd1; smp[1] = 32'd1;
        push_exp(0, 64'd2, 1'b0);
        send_burst(0, 2, wcyc);
        wait_drain();

        // Stall in ACCUM: one beat then no more valid
        cfg_len = 8'd4;
        smp[0] = 32'd10;
`ifdef ACC_SCHED_TIMEOUT_EN
        push_exp(2, 64'd10, 1'b1);
`endif
        send_burst(2, 1, wcyc);
        repeat (20) tick();
        @(negedge clk);
`ifdef ACC_SCHED_TIMEOUT_EN
        check_eq("timeout_drained", 64'(sb.size()), 64'd0);
        check_eq("timeout_busy",    64'(busy),      64'd0);
`else
        check_eq("stall_busy",      64'(busy),        64'd1);
        check_eq("stall_res_valid", 64'(res_valid),   64'd0);
        check_eq("stall_req_ready", 64'(req_ready),   64'b0100);
        check_eq("stall_partial",   64'(res_partial), 64'd0);
`endif
        tick();
        do_reset();

        check_eq("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
